ov_sccb_arb: RTL and testbench

- Shares one ov_sccb master between NUM_REQ requesters using round-robin arbitration.
- Typical requesters: the left and right camera init sequencers, plus a runtime register-access port.
- Each request is one complete SCCB transaction (3-phase write or 2-phase read).
- The block sequences the master start/busy/done handshake and returns read data and a completion pulse to the owning requester.

---
 rtl/ov_sccb_arb.sv | 197 +++++++++++++++++++
 tb/tb_ov_sccb_arb.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov_sccb_arb.sv
// ov_sccb_arb: round-robin sharing of one ov_sccb master between NUM_REQ requesters.
// Define SCCB_ARB_TIMEOUT_EN to abort transactions that run longer than TIMEOUT_CYCLES.
module ov_sccb_arb #(
    parameter int          NUM_REQ        = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [8*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_subaddr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   req_done,
    output logic                 req_err,
    output logic [7:0]           rdata,
    output logic                 m_start,
    output logic [7:0]           m_addr,
    output logic [7:0]           m_subaddr,
    output logic [7:0]           m_wdata,
    input  logic [7:0]           m_rdata,
    input  logic                 m_busy,
    input  logic                 m_done,
    output logic                 idle
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_last_q, rr_last_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          m_start_q, m_start_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    sub_q, sub_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;

    logic [IW-1:0] idx_c, win_idx;
    logic          win_found, sel_rw;
    logic [7:0]    sel_addr, sel_sub, sel_wdata;

    // Round-robin search starts just after the last owner and wraps.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx_c     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_c = IW'((int'(rr_last_q) + k) % NUM_REQ);
            if (!win_found && req[idx_c]) begin
                win_found = 1'b1;
                win_idx   = idx_c;
            end
        end
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_sub   = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IW'(i)) begin
                sel_rw    = req_rw[i];
                sel_addr  = req_addr[8*i +: 8];
                sel_sub   = req_subaddr[8*i +: 8];
                sel_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    logic tmo_hit;

`ifdef SCCB_ARB_TIMEOUT_EN
    logic [23:0] tmo_q, tmo_d;
    logic        err_q, err_d;

    assign tmo_hit = ((state_q == S_START) || (state_q == S_WAIT)) &&
                     (tmo_q == TIMEOUT_CYCLES - 24'd1);

    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (win_found) err_d = 1'b0;
            end
            S_START, S_WAIT: begin
                tmo_d = tmo_q + 24'd1;
                if (tmo_hit) err_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign req_err = (state_q == S_RESP) && err_q;
`else
    assign tmo_hit = 1'b0;
    assign req_err = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no path infers a latch.
        state_d   = state_q;
        rr_last_d = rr_last_q;
        owner_d   = owner_q;
        m_start_d = m_start_q;
        addr_d    = addr_q;
        sub_d     = sub_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    addr_d  = {sel_addr[7:1], sel_rw};
                    sub_d   = sel_subaddr_fix(sel_sub);
                    wdata_d = sel_wdata;
                    state_d = S_START;
                end
            end
            S_START: begin
                m_start_d = 1'b1;
                // Only trust the handshake once the master has actually seen start.
                if (m_start_q && m_done) begin
                    m_start_d = 1'b0;
                    rdata_d   = addr_q[0] ? m_rdata : 8'h00;
                    state_d   = S_RESP;
                end else if (m_start_q && m_busy) begin
                    m_start_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (m_done) begin
                    rdata_d = addr_q[0] ? m_rdata : 8'h00;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rr_last_d = owner_q;
                state_d   = S_IDLE;
            end
        endcase
        if (tmo_hit) begin
            m_start_d = 1'b0;
            rdata_d   = 8'hFF;
            state_d   = S_RESP;
        end
    end

    function automatic logic [7:0] sel_subaddr_fix(input logic [7:0] s);
        return s;
    endfunction

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is sampled only inside the clocked branch.
        if (!reset) begin
            state_q   <= S_IDLE;
            rr_last_q <= IW'(NUM_REQ - 1);
            owner_q   <= '0;
            m_start_q <= 1'b0;
            addr_q    <= '0;
            sub_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            owner_q   <= owner_d;
            m_start_q <= m_start_d;
            addr_q    <= addr_d;
            sub_q     <= sub_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    assign gnt       = (state_q == S_IDLE) ? '0 : (NUM_REQ'(1) << owner_q);
    assign req_done  = (state_q == S_RESP) ? gnt : '0;
    assign rdata     = rdata_q;
    assign m_start   = m_start_q;
    assign m_addr    = addr_q;
    assign m_subaddr = sub_q;
    assign m_wdata   = wdata_q;
    assign idle      = (state_q == S_IDLE) && (req == '0);

endmodule

// File: tb/tb_ov_sccb_arb.sv
// tb_ov_sccb_arb: random and directed stimulus for ov_sccb_arb against a transaction-level
// model of round-robin arbitration plus a behavioural ov_sccb master.
module tb_ov_sccb_arb;
    localparam int N  = 2;
    localparam int TO = 100;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, req_rw, gnt, req_done;
    logic [8*N-1:0] req_addr, req_subaddr, req_wdata;
    logic           req_err, m_start, m_busy, m_done, idle;
    logic [7:0]     rdata, m_addr, m_subaddr, m_wdata, m_rdata;

    always #5 clk = ~clk;

    ov_sccb_arb #(.NUM_REQ(N), .TIMEOUT_CYCLES(24'(TO))) dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_subaddr(req_subaddr), .req_wdata(req_wdata), .gnt(gnt), .req_done(req_done),
        .req_err(req_err), .rdata(rdata), .m_start(m_start), .m_addr(m_addr),
        .m_subaddr(m_subaddr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_busy(m_busy),
        .m_done(m_done), .idle(idle)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the master, what it asked for, what it should get back.
    int         rr_last = N - 1;
    int         owner = -1;
    int         age = 0;
    logic [7:0] x_addr, x_sub, x_wd;
    logic       x_rw;
    bit         start_seen = 0, gap_chk = 0;
    int         grant_log[$];
    int         done_total = 0;

    // Behavioural master: 0 = busy then done, 1 = done without busy, 2 = never finishes.
    int         mmode = 0, mlat = 3, mcnt = 0, txn_mode = 0;
    bit         mrand = 0, mact = 0, mrd_fixed_en = 0;
    logic [7:0] mrd_fixed = 8'h00, mrd_done = 8'h00;

    bit         rand_en = 0;
    logic [N-1:0] keep = '0;

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] s,
                           input logic [7:0] d, input logic rw);
        logic [8*N-1:0] fm;
        logic [N-1:0]   bm;
        fm = (8*N)'(8'hFF) << (8*i);
        bm = N'(1) << i;
        req_addr    = (req_addr & ~fm) | ((8*N)'(a) << (8*i));
        req_subaddr = (req_subaddr & ~fm) | ((8*N)'(s) << (8*i));
        req_wdata   = (req_wdata & ~fm) | ((8*N)'(d) << (8*i));
        req_rw      = rw ? (req_rw | bm) : (req_rw & ~bm);
    endtask

    task automatic set_rand(input int i);
        set_req(i, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic cycle();
        logic [8*N-1:0] t;
        @(negedge clk);
        if (!reset) begin
            check("rst_gnt", 32'(gnt), 0);
            check("rst_m_start", 32'(m_start), 0);
            check("rst_req_done", 32'(req_done), 0);
            owner = -1; rr_last = N - 1; start_seen = 0; gap_chk = 0;
            mact = 0; m_busy = 1'b0; m_done = 1'b0;
            return;
        end
        check("gnt_onehot0", 32'($onehot0(gnt)), 1);
        if (gap_chk) begin
            check("gnt_gap", 32'(gnt), 0);
            gap_chk = 0;
        end
        if (owner < 0 && gnt != '0) begin
            int w = -1;
            for (int k = 1; k <= N; k++) begin
                int idx = (rr_last + k) % N;
                if (w < 0 && ((req >> idx) & N'(1)) != '0) w = idx;
            end
            if (w < 0) check("gnt_without_req", 32'(gnt), 0);
            else begin
                check("gnt_winner", 32'(gnt), 32'(N'(1) << w));
                owner = w; age = 0; start_seen = 0;
                t = req_addr >> (8*w);    x_addr = t[7:0];
                t = req_subaddr >> (8*w); x_sub  = t[7:0];
                t = req_wdata >> (8*w);   x_wd   = t[7:0];
                x_rw = ((req_rw >> w) & N'(1)) != '0;
                grant_log.push_back(w);
            end
        end else if (owner >= 0) begin
            age++;
            check("gnt_hold", 32'(gnt), 32'(N'(1) << owner));
        end
        if (m_start) check("start_owned", 32'(owner >= 0 && (!start_seen || age <= mlat + 2)), 1);
        if (owner >= 0 && m_start && !start_seen) begin
            start_seen = 1;
            check("start_latency", 32'(age), 1);
            check("m_addr", 32'(m_addr), 32'({x_addr[7:1], x_rw}));
            check("m_subaddr", 32'(m_subaddr), 32'(x_sub));
            check("m_wdata", 32'(m_wdata), 32'(x_wd));
        end
        if (req_done != '0) begin
            if (owner < 0) check("stray_done", 32'(req_done), 0);
            else begin
                check("done_owner", 32'(req_done), 32'(N'(1) << owner));
                check("done_err", 32'(req_err), 32'(txn_mode == 2));
                check("done_rdata", 32'(rdata),
                      32'(txn_mode == 2 ? 8'hFF : (x_rw ? mrd_done : 8'h00)));
                check("m_fields_stable", {8'h00, m_addr, m_subaddr, m_wdata},
                      {8'h00, x_addr[7:1], x_rw, x_sub, x_wd});
                if (txn_mode == 2) check("timeout_cycle", 32'(age), 32'(TO));
                rr_last = owner; owner = -1; gap_chk = 1; done_total++;
            end
        end
        if (owner >= 0 && age > 3*TO) begin
            check("txn_stuck", 32'(age), 0);
            owner = -1;
        end

        // Master model
        m_done = 1'b0;
        if (req_done != '0) begin
            mact = 0; m_busy = 1'b0;
        end else if (!mact && m_start) begin
            mact = 1; mcnt = 0;
            if (mrand) begin
                mmode = $urandom_range(0, 1);
                mlat  = $urandom_range(1, 6);
            end
            txn_mode = mmode;
            m_busy = (mmode != 1);
        end else if (mact) begin
            mcnt++;
            if (mmode != 2 && mcnt >= mlat) begin
                m_done = 1'b1; m_busy = 1'b0; mact = 0;
                m_rdata = mrd_fixed_en ? mrd_fixed : 8'($urandom);
                mrd_done = m_rdata;
            end
        end
        if (!m_done) m_rdata = 8'($urandom);

        // Requester model
        for (int i = 0; i < N; i++) begin
            logic [N-1:0] bm;
            bm = N'(1) << i;
            if (!rand_en) begin
                if ((req_done & bm) != '0 && (keep & bm) == '0) req &= ~bm;
            end else if ((req_done & bm) != '0) begin
                if ($urandom_range(0, 1) == 1) set_rand(i);
                else req &= ~bm;
            end else if ((req & bm) == '0) begin
                if ($urandom_range(0, 3) == 0) begin
                    set_rand(i);
                    req |= bm;
                end
            end else if ((gnt & bm) == '0) begin
                if ($urandom_range(0, 15) == 0) req &= ~bm;
            end else if ($urandom_range(0, 7) == 0) begin
                set_rand(i);
                if ($urandom_range(0, 1) == 1) req &= ~bm;
            end
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) cycle();
        reset = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        cycle();
        while (req_done == '0 && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_done_seen"}, 32'(req_done != '0), 1);
    endtask

    initial begin
        int base, n;
        reset = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_subaddr = '0; req_wdata = '0;
        m_busy = 1'b0; m_done = 1'b0; m_rdata = 8'h00;
        repeat (3) cycle();
        check("rst_idle", 32'(idle), 1);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_m_fields", {8'h00, m_addr, m_subaddr, m_wdata}, 0);
        check("rst_err", 32'(req_err), 0);
        reset = 1'b1;
        cycle();
        check("idle_after_rst", 32'(idle), 1);

        // Single write from requester 0
        mmode = 0; mlat = 3;
        set_req(0, 8'h43, 8'h12, 8'h80, 1'b0);
        req = N'(1);
        cycle();
        check("t1_gnt", 32'(gnt), 1);
        check("t1_start_not_yet", 32'(m_start), 0);
        check("t1_not_idle", 32'(idle), 0);
        cycle();
        check("t1_start", 32'(m_start), 1);
        check("t1_m_addr", 32'(m_addr), 32'h42);
        check("t1_m_subaddr", 32'(m_subaddr), 32'h12);
        check("t1_m_wdata", 32'(m_wdata), 32'h80);
        wait_done("t1", 40);
        check("t1_req_done", 32'(req_done), 1);
        check("t1_req_err", 32'(req_err), 0);
        cycle();
        check("t1_pulse_one_cycle", 32'(req_done), 0);

        // Both requesting continuously: strict alternation from requester 0
        do_reset(2);
        grant_log.delete();
        mmode = 0; mlat = 6; keep = '1;
        set_req(0, 8'h60, 8'h01, 8'hA1, 1'b0);
        set_req(1, 8'h42, 8'h02, 8'hB2, 1'b0);
        req = '1;
        repeat (4) wait_done("t2", 40);
        check("t2_count", 32'(grant_log.size()), 4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++)
            check("t2_order", 32'(grant_log[k]), 32'(k % 2));

        // Reset while requester 1 sits in the wait phase
        wait_done("t6_pre", 40);
        n = 0;
        while (!(owner == 1 && m_busy) && n < 60) begin
            cycle();
            n++;
        end
        check("t6_reached_wait", 32'(owner == 1 && m_busy), 1);
        cycle();
        reset = 1'b0;
        cycle();
        check("t6_start_cleared", 32'(m_start), 0);
        check("t6_gnt_cleared", 32'(gnt), 0);
        check("t6_no_done", 32'(req_done), 0);
        reset = 1'b1;
        cycle();
        check("t6_first_gnt", 32'(gnt), 1);
        keep = '0; req = '0;
        repeat (20) cycle();
        check("t6_drained", 32'(idle), 1);

        // Read from requester 1
        mrd_fixed_en = 1; mrd_fixed = 8'h76; mlat = 2;
        set_req(1, 8'h42, 8'h0A, 8'h00, 1'b1);
        req = N'(2);
        cycle();
        cycle();
        check("t3_m_addr", 32'(m_addr), 32'h43);
        wait_done("t3", 40);
        check("t3_req_done", 32'(req_done), 2);
        check("t3_rdata", 32'(rdata), 32'h76);
        mrd_fixed_en = 0;
        repeat (4) cycle();

        // Fast master: done with no busy
        mmode = 1; mlat = 3;
        base = done_total;
        set_req(0, 8'h21, 8'h33, 8'h44, 1'b1);
        req = N'(1);
        wait_done("t4", 40);
        check("t4_req_done", 32'(req_done), 1);
        repeat (10) cycle();
        check("t4_single_done", 32'(done_total - base), 1);
        check("t4_idle", 32'(idle), 1);

        // Random traffic
        base = done_total;
        mrand = 1; rand_en = 1;
        repeat (3000) cycle();
        rand_en = 0; mrand = 0; req = '0;
        repeat (40) cycle();
        check("rand_drained", 32'(idle), 1);
        check("rand_progress", 32'(done_total - base > 100), 1);

`ifdef SCCB_ARB_TIMEOUT_EN
        // Master never answers: abort after TO cycles, then serve the other requester
        do_reset(2);
        mmode = 2; keep = '1;
        set_req(0, 8'h10, 8'h20, 8'h30, 1'b1);
        set_req(1, 8'h50, 8'h60, 8'h70, 1'b0);
        req = '1;
        wait_done("t7", 3*TO);
        check("t7_req_err", 32'(req_err), 1);
        check("t7_rdata", 32'(rdata), 32'hFF);
        cycle();
        cycle();
        check("t7_next_gnt", 32'(gnt), 2);
        do_reset(2);
        keep = '0; req = '0; mmode = 0;
        repeat (4) cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
